// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared constants for the GPIO register bank: register offsets relative to
// the bank base address, the default base address and the legacy write alias
// that older programs use to drive the output pins.
package gpio_pkg;

   localparam logic [31:0] DEFAULT_BASE = 32'h0000_AB00;
   localparam logic [31:0] LEGACY_ADDR  = 32'h0000_ABCD;

   localparam logic [31:0] OFF_DATA_OUT = 32'h00;
   localparam logic [31:0] OFF_DIR      = 32'h04;
   localparam logic [31:0] OFF_DATA_IN  = 32'h08;
   localparam logic [31:0] OFF_IRQ_EN   = 32'h0C;
   localparam logic [31:0] OFF_EDGE_SEL = 32'h10;
   localparam logic [31:0] OFF_IRQ_STAT = 32'h14;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
// Brings asynchronous pin inputs into the clock domain through a chain of
// SYNC_STAGES flops, keeps one history flop of the synchronised value and
// produces a one-cycle event per bit on the selected edge.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   pins         raw asynchronous pin inputs
//   edge_sel     per-bit edge select, 0 = rising, 1 = falling
//   sync_in      synchronised pin values
//   events       per-bit edge events (combinational from sync_in/prev_in)
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pins,
   input  logic [WIDTH-1:0] edge_sel,
   output logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] events
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];
   logic [WIDTH-1:0] prev_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
         prev_in <= '0;
      end else begin
         stage[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
         prev_in <= stage[SYNC_STAGES-1];
      end
   end

   assign sync_in = stage[SYNC_STAGES-1];

   // The edge selection is applied live, so a change of edge_sel only
   // affects comparisons made from the next clock edge onwards.
   assign events = (sync_in & ~prev_in & ~edge_sel) |
                   (~sync_in & prev_in & edge_sel);

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank
// Memory-mapped GPIO register bank on the data-memory bus. Provides WIDTH
// bidirectional lines with per-bit direction, synchronised read-back and
// edge-detect interrupts, and still honours the legacy DATA_OUT write alias.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   address_gpio   bus byte address
//   dato_gpio      bus write data
//   we_gpio        write strobe
//   re_gpio        read strobe
//   rdata_gpio     registered read data, held between reads
//   rvalid_gpio    one-cycle pulse qualifying rdata_gpio
//   gpio_in        asynchronous pin inputs
//   gpio_out       pin output values
//   gpio_oe        pin output enables (1 = drive)
//   irq            registered level interrupt
module gpio_bank
   import gpio_pkg::*;
#(
   parameter int          WIDTH       = 32,
   parameter logic [31:0] BASE_ADDR   = gpio_pkg::DEFAULT_BASE,
   parameter logic [31:0] LEGACY_ADDR = gpio_pkg::LEGACY_ADDR,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      address_gpio,
   input  logic [31:0]      dato_gpio,
   input  logic             we_gpio,
   input  logic             re_gpio,
   output logic [31:0]      rdata_gpio,
   output logic             rvalid_gpio,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam logic [31:0] A_DATA_OUT = BASE_ADDR + OFF_DATA_OUT;
   localparam logic [31:0] A_DIR      = BASE_ADDR + OFF_DIR;
   localparam logic [31:0] A_DATA_IN  = BASE_ADDR + OFF_DATA_IN;
   localparam logic [31:0] A_IRQ_EN   = BASE_ADDR + OFF_IRQ_EN;
   localparam logic [31:0] A_EDGE_SEL = BASE_ADDR + OFF_EDGE_SEL;
   localparam logic [31:0] A_IRQ_STAT = BASE_ADDR + OFF_IRQ_STAT;

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irq_en;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] irq_stat;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] events;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] stat_clear;
   logic [31:0]      read_mux;

   logic wr_data_out;
   logic wr_dir;
   logic wr_irq_en;
   logic wr_edge_sel;
   logic wr_irq_stat;

   gpio_sync_edge #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .pins    (gpio_in),
      .edge_sel(edge_sel),
      .sync_in (sync_in),
      .events  (events)
   );

   assign wdata = dato_gpio[WIDTH-1:0];

   // Exact address decode; the legacy alias is a second name for DATA_OUT.
   assign wr_data_out = we_gpio && ((address_gpio == A_DATA_OUT) ||
                                    (address_gpio == LEGACY_ADDR));
   assign wr_dir      = we_gpio && (address_gpio == A_DIR);
   assign wr_irq_en   = we_gpio && (address_gpio == A_IRQ_EN);
   assign wr_edge_sel = we_gpio && (address_gpio == A_EDGE_SEL);
   assign wr_irq_stat = we_gpio && (address_gpio == A_IRQ_STAT);

   assign stat_clear = wr_irq_stat ? wdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         dir      <= '0;
         irq_en   <= '0;
         edge_sel <= '0;
         irq_stat <= '0;
      end else begin
         if (wr_data_out) data_out <= wdata;
         if (wr_dir)      dir      <= wdata;
         if (wr_irq_en)   irq_en   <= wdata;
         if (wr_edge_sel) edge_sel <= wdata;
         // New events are OR-ed in after the clear so a set landing on the
         // same edge as a write-1-to-clear keeps the bit set.
         irq_stat <= (irq_stat & ~stat_clear) | events;
      end
   end

   // Read data is built from the current register values, so a read that
   // coincides with a write to the same register sees the old contents.
   always_comb begin
      read_mux = '0;
      case (address_gpio)
         A_DATA_OUT: read_mux[WIDTH-1:0] = data_out;
         A_DIR:      read_mux[WIDTH-1:0] = dir;
         A_DATA_IN:  read_mux[WIDTH-1:0] = sync_in;
         A_IRQ_EN:   read_mux[WIDTH-1:0] = irq_en;
         A_EDGE_SEL: read_mux[WIDTH-1:0] = edge_sel;
         A_IRQ_STAT: read_mux[WIDTH-1:0] = irq_stat;
         default:    read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_gpio  <= '0;
         rvalid_gpio <= 1'b0;
      end else begin
         rvalid_gpio <= re_gpio;
         if (re_gpio) rdata_gpio <= read_mux;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(irq_stat & irq_en);
      end
   end

   assign gpio_out = data_out;
   assign gpio_oe  = dir;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank
// Directed bench for gpio_bank with default parameters: register access,
// legacy alias, edge interrupts, set-versus-clear priority and reset.
module tb_gpio_bank;

   localparam logic [31:0] BASE     = 32'h0000_AB00;
   localparam logic [31:0] A_OUT    = BASE + 32'h00;
   localparam logic [31:0] A_DIR    = BASE + 32'h04;
   localparam logic [31:0] A_IN     = BASE + 32'h08;
   localparam logic [31:0] A_EN     = BASE + 32'h0C;
   localparam logic [31:0] A_SEL    = BASE + 32'h10;
   localparam logic [31:0] A_STAT   = BASE + 32'h14;
   localparam logic [31:0] A_LEGACY = 32'h0000_ABCD;

   logic        clk;
   logic        rst_n;
   logic [31:0] address_gpio;
   logic [31:0] dato_gpio;
   logic        we_gpio;
   logic        re_gpio;
   logic [31:0] rdata_gpio;
   logic        rvalid_gpio;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   logic [31:0] gpio_oe;
   logic        irq;

   int compared;
   int mismatched;

   logic [31:0] rd;
   logic        rv;

   gpio_bank dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .address_gpio(address_gpio),
      .dato_gpio   (dato_gpio),
      .we_gpio     (we_gpio),
      .re_gpio     (re_gpio),
      .rdata_gpio  (rdata_gpio),
      .rvalid_gpio (rvalid_gpio),
      .gpio_in     (gpio_in),
      .gpio_out    (gpio_out),
      .gpio_oe     (gpio_oe),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one write strobe across a single rising edge and returns 1ns
   // after that edge so callers can sample the immediate effect.
   task automatic apply_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      address_gpio = addr;
      dato_gpio    = data;
      we_gpio      = 1'b1;
      @(posedge clk);
      #1;
      we_gpio = 1'b0;
   endtask

   // Issues one read strobe and returns the sampled rdata/rvalid.
   task automatic apply_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic valid);
      @(negedge clk);
      address_gpio = addr;
      re_gpio      = 1'b1;
      @(posedge clk);
      #1;
      data    = rdata_gpio;
      valid   = rvalid_gpio;
      re_gpio = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      compared++; if (gpio_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_out got %h want 0", gpio_out); end
      compared++; if (gpio_oe !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_oe got %h want 0", gpio_oe); end
      compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
      compared++; if (rvalid_gpio !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rvalid got %b want 0", rvalid_gpio); end
      compared++; if (rdata_gpio !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata got %h want 0", rdata_gpio); end
   endtask

   task automatic test_legacy;
      apply_write(32'd16, 32'd96);
      compared++; if (gpio_out !== 32'h0) begin mismatched++; $display("[TB] FAIL unmapped_write got %h want 0", gpio_out); end
      apply_write(A_LEGACY, 32'd96);
      compared++; if (gpio_out !== 32'd96) begin mismatched++; $display("[TB] FAIL legacy_write got %h want 60", gpio_out); end
      compared++; if (gpio_oe !== 32'h0) begin mismatched++; $display("[TB] FAIL legacy_oe got %h want 0", gpio_oe); end
      apply_read(A_LEGACY, rd, rv);
      compared++; if (rv !== 1'b1) begin mismatched++; $display("[TB] FAIL legacy_read_valid got %b want 1", rv); end
      compared++; if (rd !== 32'h0) begin mismatched++; $display("[TB] FAIL legacy_read_data got %h want 0", rd); end
   endtask

   task automatic test_dir_data;
      apply_write(A_DIR, 32'hFFFF_0000);
      apply_write(A_OUT, 32'h1234_5678);
      compared++; if (gpio_oe !== 32'hFFFF_0000) begin mismatched++; $display("[TB] FAIL dir_oe got %h want ffff0000", gpio_oe); end
      compared++; if (gpio_out !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL data_out got %h want 12345678", gpio_out); end
      apply_read(A_DIR, rd, rv);
      compared++; if (rv !== 1'b1) begin mismatched++; $display("[TB] FAIL read_dir_valid got %b want 1", rv); end
      compared++; if (rd !== 32'hFFFF_0000) begin mismatched++; $display("[TB] FAIL read_dir got %h want ffff0000", rd); end
      @(posedge clk); #1;
      compared++; if (rvalid_gpio !== 1'b0) begin mismatched++; $display("[TB] FAIL rvalid_pulse got %b want 0", rvalid_gpio); end
      compared++; if (rdata_gpio !== 32'hFFFF_0000) begin mismatched++; $display("[TB] FAIL rdata_hold got %h want ffff0000", rdata_gpio); end
      apply_read(A_OUT, rd, rv);
      compared++; if (rd !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL read_out got %h want 12345678", rd); end
      apply_read(BASE + 32'h18, rd, rv);
      compared++; if (rv !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("[TB] FAIL read_unmapped got %h/%b want 0/1", rd, rv); end
      apply_write(A_IN, 32'hFFFF_FFFF);
      apply_read(A_IN, rd, rv);
      compared++; if (rd !== 32'h0) begin mismatched++; $display("[TB] FAIL data_in_ro got %h want 0", rd); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      address_gpio = A_OUT;
      dato_gpio    = 32'hCAFE_F00D;
      we_gpio      = 1'b1;
      re_gpio      = 1'b1;
      @(posedge clk);
      #1;
      we_gpio = 1'b0;
      re_gpio = 1'b0;
      compared++; if (rdata_gpio !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL rw_same_reg got %h want 12345678", rdata_gpio); end
      compared++; if (gpio_out !== 32'hCAFE_F00D) begin mismatched++; $display("[TB] FAIL rw_same_out got %h want cafef00d", gpio_out); end
      apply_read(A_OUT, rd, rv);
      compared++; if (rd !== 32'hCAFE_F00D) begin mismatched++; $display("[TB] FAIL rw_readback got %h want cafef00d", rd); end
   endtask

   task automatic test_rising_irq;
      apply_write(A_EN, 32'h8);
      @(negedge clk);
      gpio_in[3] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      address_gpio = A_STAT;
      re_gpio      = 1'b1;
      @(posedge clk); #1;
      compared++; if (rdata_gpio !== 32'h0) begin mismatched++; $display("[TB] FAIL stat_early got %h want 0", rdata_gpio); end
      compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_early got %b want 0", irq); end
      @(posedge clk); #1;
      re_gpio = 1'b0;
      compared++; if (rdata_gpio !== 32'h8) begin mismatched++; $display("[TB] FAIL stat_rise got %h want 8", rdata_gpio); end
      compared++; if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_rise got %b want 1", irq); end
      apply_read(A_IN, rd, rv);
      compared++; if (rd !== 32'h8) begin mismatched++; $display("[TB] FAIL data_in got %h want 8", rd); end
      apply_write(A_STAT, 32'h8);
      compared++; if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_clr_lag got %b want 1", irq); end
      @(posedge clk); #1;
      compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_cleared got %b want 0", irq); end
      @(negedge clk);
      gpio_in[3] = 1'b0;
      wait_cycles(5);
      apply_read(A_STAT, rd, rv);
      compared++; if (rd !== 32'h0) begin mismatched++; $display("[TB] FAIL fall_no_set got %h want 0", rd); end
   endtask

   task automatic test_falling_edge_sel;
      apply_write(A_EN, 32'h0);
      apply_write(A_SEL, 32'h20);
      apply_read(A_SEL, rd, rv);
      compared++; if (rd !== 32'h20) begin mismatched++; $display("[TB] FAIL edge_sel_rb got %h want 20", rd); end
      @(negedge clk);
      gpio_in[5] = 1'b1;
      wait_cycles(4);
      apply_read(A_STAT, rd, rv);
      compared++; if (rd !== 32'h0) begin mismatched++; $display("[TB] FAIL rise_ignored got %h want 0", rd); end
      gpio_in[5] = 1'b0;
      wait_cycles(5);
      compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_masked got %b want 0", irq); end
      apply_read(A_STAT, rd, rv);
      compared++; if (rd !== 32'h20) begin mismatched++; $display("[TB] FAIL stat_fall got %h want 20", rd); end
      apply_write(A_EN, 32'h20);
      compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_en_lag got %b want 0", irq); end
      @(posedge clk); #1;
      compared++; if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_en_raise got %b want 1", irq); end
      apply_write(A_STAT, 32'h20);
      @(posedge clk); #1;
      compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_w1c got %b want 0", irq); end
   endtask

   task automatic test_set_wins;
      @(negedge clk);
      gpio_in[3] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      address_gpio = A_STAT;
      dato_gpio    = 32'h8;
      we_gpio      = 1'b1;
      @(posedge clk); #1;
      we_gpio = 1'b0;
      apply_read(A_STAT, rd, rv);
      compared++; if (rd !== 32'h8) begin mismatched++; $display("[TB] FAIL set_wins got %h want 8", rd); end
      apply_write(A_STAT, 32'h0);
      apply_read(A_STAT, rd, rv);
      compared++; if (rd !== 32'h8) begin mismatched++; $display("[TB] FAIL w0_no_effect got %h want 8", rd); end
   endtask

   task automatic test_reset_mid_read;
      apply_write(A_EN, 32'h8);
      @(posedge clk); #1;
      compared++; if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL pre_reset_irq got %b want 1", irq); end
      @(negedge clk);
      address_gpio = A_STAT;
      re_gpio      = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      compared++; if (gpio_out !== 32'h0 || gpio_oe !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_reset_pins got %h/%h want 0/0", gpio_out, gpio_oe); end
      compared++; if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_irq got %b want 0", irq); end
      compared++; if (rdata_gpio !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_reset_rdata got %h want 0", rdata_gpio); end
      @(posedge clk); #1;
      compared++; if (rvalid_gpio !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_rvalid got %b want 0", rvalid_gpio); end
      re_gpio = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      apply_read(A_STAT, rd, rv);
      compared++; if (rv !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("[TB] FAIL post_reset_stat got %h/%b want 0/1", rd, rv); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst_n        = 1'b0;
      address_gpio = '0;
      dato_gpio    = '0;
      we_gpio      = 1'b0;
      re_gpio      = 1'b0;
      gpio_in      = '0;
      wait_cycles(3);
      test_reset;
      rst_n = 1'b1;
      wait_cycles(2);
      test_legacy;
      test_dir_data;
      test_back_to_back;
      test_rising_irq;
      test_falling_edge_sel;
      test_set_wins;
      test_reset_mid_read;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
